// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   - IFU_XLEN / IFU_RESET_PC / IFU_NOP_INST: default datapath width, reset PC, bubble word
//   - ifu_state_e: fetch FSM states
//   - fetch_pkt_t: instruction packet presented to decode {pc, inst, exc}
//   - is_misaligned(): word-alignment test for a fetch address
package ifu_pkg;

    localparam int unsigned IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] inst;
        logic                exc;
    } fetch_pkt_t;

    function automatic logic is_misaligned(input logic [IFU_XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: architectural program counter.
// Next-PC priority is redirect > sequential increment > hold.
// Ports:
//   clk, reset   clock and asynchronous active-low reset (reset loads RESET_PC)
//   redirect_en  load redirect_pc this cycle
//   redirect_pc  redirect target
//   incr_en      advance by one instruction word (wraps modulo 2^XLEN)
//   pc           current PC
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            incr_en,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = redirect_pc;
        end else if (incr_en) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the single-cycle core.
// Issues one word-aligned read at a time, waits for the response, and presents
// {pc, inst, exc} to decode on a valid/ready port. Redirects from execute
// squash whatever fetch is in flight.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   instruction memory request channel
//   rsp_valid/rsp_data/rsp_err     instruction memory response (always accepted)
//   out_valid/out_ready            decode handshake
//   out_pc/out_inst/out_exc        delivered packet (exc: misaligned PC or access fault)
//   redirect_valid/redirect_pc     PC change request from execute
//   fetch_cnt                      number of instructions consumed by decode
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = IFU_NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    // instruction memory request
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    // instruction memory response
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            rsp_err,
    // decode port
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_exc,
    // redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // statistics
    output logic [31:0]     fetch_cnt
);

    ifu_state_e      state_q;
    ifu_state_e      state_d;
    logic            alive_q;
    logic            drop_q;
    logic            drop_d;
    fetch_pkt_t      pkt_q;
    fetch_pkt_t      pkt_d;
    logic [31:0]     fetch_cnt_q;
    logic [XLEN-1:0] pc;

    logic pc_misaligned;
    logic req_fire;
    logic rsp_take;
    logic mis_enter;
    logic out_fire;
    logic out_leave;

    assign pc_misaligned = is_misaligned(pc);

    // Handshake with memory; req_valid comes from the output process below.
    assign req_fire  = req_valid && req_ready;
    // Response becomes the next packet only if nothing has squashed this fetch.
    assign rsp_take  = (state_q == S_WAIT) && rsp_valid && !drop_q && !redirect_valid;
    // A misaligned PC never reaches memory; it is reported as a faulting bubble.
    assign mis_enter = (state_q == S_REQ) && alive_q && pc_misaligned && !redirect_valid;
    // Redirect wins over consumption: a squashed packet is neither counted nor advances pc.
    assign out_fire  = (state_q == S_OUT) && out_ready && !redirect_valid;
    assign out_leave = (state_q == S_OUT) && (out_ready || redirect_valid);

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .redirect_en (redirect_valid),
        .redirect_pc (redirect_pc),
        .incr_en     (out_fire),
        .pc          (pc)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (mis_enter) begin
                    state_d = S_OUT;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_d = rsp_take ? S_OUT : S_REQ;
                end
            end
            S_OUT: begin
                if (out_ready || redirect_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // alive_q holds off the request until the first edge after reset release.
        req_valid = alive_q && (state_q == S_REQ) && !pc_misaligned;
        req_addr  = pc;
        out_valid = (state_q == S_OUT);
        out_pc    = pkt_q.pc;
        out_inst  = pkt_q.inst;
        out_exc   = pkt_q.exc;
        fetch_cnt = fetch_cnt_q;
    end

    // ---------------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------------
    always_comb begin
        drop_d = drop_q;
        if (req_fire) begin
            // Redirect on the handshake cycle: the request is already gone, so mark it stale.
            drop_d = redirect_valid;
        end else if (state_q == S_WAIT) begin
            if (rsp_valid) begin
                drop_d = 1'b0;
            end else if (redirect_valid) begin
                drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        pkt_d = pkt_q;
        if (rsp_take) begin
            pkt_d.pc   = pc;
            pkt_d.inst = rsp_data;
            pkt_d.exc  = rsp_err;
        end else if (mis_enter) begin
            pkt_d.pc   = pc;
            pkt_d.inst = NOP_INST;
            pkt_d.exc  = 1'b1;
        end else if (out_leave) begin
            // Consumed or squashed: drop back to a clean bubble, exception is not sticky.
            pkt_d.inst = NOP_INST;
            pkt_d.exc  = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q     <= 1'b0;
            drop_q      <= 1'b0;
            pkt_q.pc    <= RESET_PC;
            pkt_q.inst  <= NOP_INST;
            pkt_q.exc   <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            alive_q <= 1'b1;
            drop_q  <= drop_d;
            pkt_q   <= pkt_d;
            if (out_fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the single-cycle core datapath.
- Owns the architectural PC and issues one word-aligned read at a time to instruction memory over a request/response channel.
- Delivers each fetched instruction with its PC on a valid/ready port that replaces the core's direct pc/ist wiring.
- Accepts redirects (branch/jump target) from execute and squashes any stale fetch.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h80000000, PC value loaded on reset.
- NOP_INST, 32'h00000013, value driven on out_inst when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts the request this cycle.
- req_addr  out  XLEN  word-aligned fetch address; sampled by memory only on the handshake cycle.
- rsp_valid  in  1  read data valid, one-cycle pulse; the stage is always ready.
- rsp_data  in  XLEN  instruction word.
- rsp_err  in  1  access fault, qualified by rsp_valid.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes the instruction this cycle.
- out_pc  out  XLEN  PC of out_inst.
- out_inst  out  XLEN  fetched instruction.
- out_exc  out  1  fetch exception: misaligned PC or rsp_err.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  XLEN  new PC.
- fetch_cnt  out  32  count of instructions delivered (out_valid && out_ready); wraps at 2^32.

Behaviour:
- Reset, asynchronous, while reset==0:
  - state=S_REQ, pc=RESET_PC, drop=0.
  - req_valid=0, out_valid=0, out_pc=RESET_PC, out_inst=NOP_INST, out_exc=0, fetch_cnt=0.
- req_valid is decoded from state and gated by a registered "out of reset" flag, so the first request asserts in the first cycle after reset releases.
- S_REQ:
  - req_valid=1, req_addr=pc.
  - If pc[1:0]!=0: req_valid=0; go to S_OUT with out_exc=1, out_inst=NOP_INST, out_pc=pc.
  - On req_valid && req_ready: go to S_WAIT.
  - redirect_valid with no handshake: pc<=redirect_pc and stay in S_REQ; req_addr may change because it is only sampled on the handshake.
  - redirect_valid on the handshake cycle: go to S_WAIT with drop=1 and pc<=redirect_pc.
- S_WAIT:
  - At most one request is outstanding.
  - On rsp_valid with drop=1 or redirect_valid: discard the response, clear drop, go to S_REQ. If redirect_valid, pc<=redirect_pc.
  - On rsp_valid with drop=0 and no redirect: latch out_inst=rsp_data, out_exc=rsp_err, out_pc=pc; go to S_OUT.
  - redirect_valid without rsp_valid: drop<=1, pc<=redirect_pc, stay in S_WAIT.
- S_OUT:
  - out_valid=1; out_pc, out_inst and out_exc are held stable until consumed.
  - On out_ready with no redirect: pc<=pc+4 (mod 2^XLEN, 32'hFFFFFFFC wraps to 0), fetch_cnt++, out_inst<=NOP_INST, go to S_REQ.
  - redirect_valid has priority over out_ready: the instruction is not counted, pc<=redirect_pc, go to S_REQ.
- Latency: with req_ready=1 and the response one cycle later, the request is in cycle N, rsp_valid in N+1, out_valid in N+2. Peak throughput is 1 instruction per 3 cycles.
- Reset asserted mid-transaction: state is cleared immediately. A late rsp_valid that arrives in S_REQ is ignored (defined as don't-care; the bench checks it does not corrupt state).
- rsp_valid outside S_WAIT is ignored.
- out_exc is not sticky; it clears when the instruction is consumed or squashed.

Decomposition:
- Shared package ifu_pkg:
  - State enum: S_REQ, S_WAIT, S_OUT.
  - RESET_PC and NOP_INST constants.
  - Fetch-packet struct {pc, inst, exc}.
- One natural sub-module, ifu_pc_reg: holds pc and computes next pc with mux priority redirect > increment > hold. Instantiated once.

Test Plan:
- Reset release, req_ready=1, memory returns 32'h00500093 one cycle after each request, out_ready=1 -> out_pc sequence 80000000, 80000004, 80000008; out_valid every third cycle; fetch_cnt=3.
- out_ready=0 for 5 cycles in S_OUT -> out_valid, out_pc=80000000 and out_inst held stable; no new req_valid; pc advances only after out_ready=1.
- redirect_valid with redirect_pc=80000100 in S_WAIT, response arrives 2 cycles later -> response discarded, no out_valid; next req_addr=80000100.
- redirect_valid (redirect_pc=80000200) and out_ready in the same cycle in S_OUT -> fetch_cnt unchanged; next req_addr=80000200.
- redirect_pc=80000102 -> no req_valid; out_valid=1, out_exc=1, out_pc=80000102, out_inst=00000013.
- rsp_err=1 on a response -> out_exc=1 with out_pc of that fetch. Then assert reset low mid-S_WAIT -> all outputs take reset values asynchronously, and the next request after release is at 80000000.
